// File: rtl/result_buffer.sv
// result_buffer: samples enabled ALU results on load into a 2**ADDR_W-entry FIFO drained by valid/ready;
// head is visible the cycle after push (no fall-through), loads into a full FIFO are dropped and set sticky overflow. Option: RESULT_FLAGS_EN.
module result_buffer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  R,
  input  logic              en,
  input  logic [2:0]        SEL,
  input  logic              load,
  output logic [WIDTH-1:0]  dout,
  output logic [2:0]        tag,
  output logic              valid,
  input  logic              ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
`ifdef RESULT_FLAGS_EN
  output logic              zf,
  output logic              nf,
`endif
  input  logic              clr_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_INC  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_INC  = (ADDR_W)'(1);

  logic [WIDTH-1:0]  mem_dat [DEPTH];
  logic [2:0]        mem_tag [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              push;
  logic              pop;
  logic              drop;

  assign valid = (count != '0);
  assign full  = (count == FULL_CNT);
  assign pop   = valid & ready;
  // A pop frees the slot being written, so a full FIFO can still accept.
  assign push  = load & en & (~full | pop);
  assign drop  = load & en & full & ~pop;

`ifdef RESULT_FLAGS_EN
  logic mem_zf [DEPTH];
  logic mem_nf [DEPTH];

  assign zf = valid & mem_zf[rd_ptr];
  assign nf = valid & mem_nf[rd_ptr];
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat[wr_ptr] <= R;
      mem_tag[wr_ptr] <= SEL;
`ifdef RESULT_FLAGS_EN
      mem_zf[wr_ptr]  <= (R == '0);
      mem_nf[wr_ptr]  <= R[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_INC;
      if (pop)  rd_ptr <= rd_ptr + PTR_INC;
      if (push && !pop)      count <= count + CNT_INC;
      else if (pop && !push) count <= count - CNT_INC;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign dout = valid ? mem_dat[rd_ptr] : '0;
  assign tag  = valid ? mem_tag[rd_ptr] : 3'b000;

endmodule
